// File: rtl/frame_fifo.sv
// Store-and-forward frame FIFO: frames are written speculatively and only become
// readable once their eof word commits error-free; bad or oversized frames roll back.
module frame_fifo #(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned DEPTH  = 4096,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     in_vld,
   input  logic                     in_eof,
   input  logic                     in_err,
   input  logic [DATA_W-1:0]        in_dat,
   output logic                     out_vld,
   output logic                     out_eof,
   output logic [DATA_W-1:0]        out_dat,
   input  logic                     out_rdy,
   output logic [$clog2(DEPTH):0]   frm_cnt,
   output logic [CNT_W-1:0]         drop_cnt,
   output logic                     ovf
);
   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned PTR_W  = ADDR_W + 1;

   typedef enum logic {ACCEPT, DROP} state_t;

   state_t             state, state_nxt;
   logic [PTR_W-1:0]   wr_ptr, wr_tmp, rd_ptr, fetch_ptr, used;
   logic               err_flag, err_nxt;
   logic               space, bad;
   logic               wr_en, commit, rollback, drop_inc, ovf_nxt;
   logic               pop, pop_eof, load_out, fetch;
   logic               s1_vld, s1_eof;
   logic [DATA_W-1:0]  s1_dat;
   logic [DATA_W:0]    mem [0:DEPTH-1];

   // rd_ptr only advances on consumption, so words parked in the output pipeline still occupy space
   assign used  = wr_tmp - rd_ptr;
   assign space = !used[ADDR_W];
   assign bad   = err_flag | in_err;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= ACCEPT;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ACCEPT: if (in_vld && !space && !in_eof) state_nxt = DROP;
         DROP:   if (in_vld && in_eof)            state_nxt = ACCEPT;
         default: state_nxt = ACCEPT;
      endcase
   end

   always_comb begin
      wr_en    = 1'b0;
      commit   = 1'b0;
      rollback = 1'b0;
      drop_inc = 1'b0;
      ovf_nxt  = 1'b0;
      err_nxt  = err_flag;
      unique case (state)
         ACCEPT: begin
            if (in_vld) begin
               if (space) begin
                  wr_en = 1'b1;
                  if (in_eof) begin
                     if (bad) begin
                        rollback = 1'b1;
                        drop_inc = 1'b1;
                        err_nxt  = 1'b0;
                     end else begin
                        commit = 1'b1;
                     end
                  end else begin
                     err_nxt = bad;
                  end
               end else begin
                  rollback = 1'b1;
                  ovf_nxt  = 1'b1;
                  err_nxt  = 1'b0;
                  drop_inc = in_eof;
               end
            end
         end
         DROP: drop_inc = in_vld & in_eof;
         default: ;
      endcase
   end

   // Write-side pointers and counters
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr   <= '0;
         wr_tmp   <= '0;
         err_flag <= 1'b0;
         ovf      <= 1'b0;
         drop_cnt <= '0;
         frm_cnt  <= '0;
      end else begin
         err_flag <= err_nxt;
         ovf      <= ovf_nxt;
         if (rollback)   wr_tmp <= wr_ptr;
         else if (wr_en) wr_tmp <= wr_tmp + 1'b1;
         if (commit)     wr_ptr <= wr_tmp + 1'b1;
         if (drop_inc && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
         unique case ({commit, pop_eof})
            2'b10:   frm_cnt <= frm_cnt + 1'b1;
            2'b01:   frm_cnt <= frm_cnt - 1'b1;
            default: ;
         endcase
      end
   end

   // Storage and the synchronous read stage feeding the output register
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_tmp[ADDR_W-1:0]] <= {in_eof, in_dat};
      if (fetch) {s1_eof, s1_dat} <= mem[fetch_ptr[ADDR_W-1:0]];
   end

   assign pop      = out_vld & out_rdy;
   assign pop_eof  = pop & out_eof;
   assign load_out = s1_vld & (!out_vld | out_rdy);
   assign fetch    = (fetch_ptr != wr_ptr) & (!s1_vld | load_out);

   // Two-stage read pipeline: read stage, then held output register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fetch_ptr <= '0;
         rd_ptr    <= '0;
         s1_vld    <= 1'b0;
         out_vld   <= 1'b0;
         out_eof   <= 1'b0;
         out_dat   <= '0;
      end else begin
         if (fetch)         fetch_ptr <= fetch_ptr + 1'b1;
         if (pop)           rd_ptr    <= rd_ptr + 1'b1;
         if (fetch)         s1_vld    <= 1'b1;
         else if (load_out) s1_vld    <= 1'b0;
         if (load_out) begin
            out_vld <= 1'b1;
            out_eof <= s1_eof;
            out_dat <= s1_dat;
         end else if (pop) begin
            out_vld <= 1'b0;
         end
      end
   end
endmodule
